// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch stage.
//   fetch_state_t    : fetch FSM states (IDLE, REQ, WAIT)
//   DEFAULT_RESET_PC : fetch PC used when no RESET_PC override is given
//   fetch_entry_t    : {pc, instr} pair for the default 32/32 configuration
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO that holds fetched instructions.
//   clk, reset  : clock, async active-low reset
//   flush       : empties the FIFO; wins over a same-cycle push or pop
//   push/data   : write one entry (caller guarantees no push when full
//                 unless a pop happens in the same cycle)
//   pop         : consume the head (ignored while empty)
//   head/valid  : head entry and non-empty flag; head holds the last shown
//                 entry while the FIFO is empty
//   count       : number of stored entries (0..DEPTH)
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [W-1:0]            last_head;
   logic                    do_pop;

   assign valid  = (count != '0);
   assign do_pop = pop && valid;

   // Decode must see a stable head while nothing is valid, so the last
   // displayed entry is kept and shown instead of a stale memory slot.
   assign head = valid ? mem[rd_ptr] : last_head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_head <= '0;
      end else begin
         if (valid)
            last_head <= mem[rd_ptr];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= push_data;
               wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop)
               rd_ptr <= rd_ptr + PW'(1);
            case ({push, do_pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage. Owns the fetch PC, issues one word-addressed
// instruction-memory request at a time, and queues {pc, instr} for decode.
//   clk, reset           : clock, async active-low reset
//   redirect_valid/_pc   : taken branch/jump target from next-address stage
//   imem_req/_addr       : memory request (registered state decode)
//   imem_gnt             : memory accepted the request
//   imem_rvalid/_rdata   : in-order response, at least one cycle after gnt
//   instr_valid/instr/pc : FIFO head presented to decode
//   instr_ready          : decode consumes the head
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0] req_pc;
   logic              outstanding, outstanding_nxt;
   logic              discard, discard_nxt;
   logic              granted, resp, push, pop, credit;
   logic [CW-1:0]     count, count_nxt;
   logic [CW:0]       credit_sum;
   entry_t            push_entry, head_entry;

   assign granted = (state == REQ) && imem_gnt;
   // rvalid is only meaningful while a request is in flight; anything else
   // (e.g. a response from before a reset) is ignored.
   assign resp    = outstanding && imem_rvalid;
   assign push    = resp && !discard && !redirect_valid;
   assign pop     = instr_valid && instr_ready;

   assign push_entry.pc    = req_pc;
   assign push_entry.instr = imem_rdata;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (ADDR_W + DATA_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .valid     (instr_valid),
      .count     (count)
   );

   assign instr    = head_entry.instr;
   assign instr_pc = head_entry.pc;

   assign imem_req  = (state == REQ);
   assign imem_addr = fetch_pc;

   // FIFO occupancy after this edge, with flush taking priority.
   always_comb begin
      count_nxt = count;
      if (redirect_valid)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + CW'(1);
      else if (pop && !push)
         count_nxt = count - CW'(1);
   end

   // PC and in-flight bookkeeping.
   always_comb begin
      fetch_pc_nxt    = fetch_pc;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;
      if (granted) begin
         outstanding_nxt = 1'b1;
         fetch_pc_nxt    = fetch_pc + ADDR_W'(1);
      end
      if (resp) begin
         outstanding_nxt = 1'b0;
         discard_nxt     = 1'b0;
      end
      if (redirect_valid) begin
         fetch_pc_nxt = redirect_pc;
         // Whatever is still in flight after this edge belongs to the old
         // path. Only one request can be in flight, so this saturates.
         discard_nxt  = outstanding_nxt;
      end
   end

   // Credit counts FIFO slots plus the in-flight request, so a response
   // always has somewhere to land.
   assign credit_sum = {1'b0, count_nxt} + {{CW{1'b0}}, outstanding_nxt};
   assign credit     = (credit_sum < DEPTH_V);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (credit) state_nxt = REQ;
         REQ:     if (granted) state_nxt = WAIT;
         WAIT:    if (resp) state_nxt = credit ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (redirect_valid)
         state_nxt = outstanding_nxt ? WAIT : (credit ? REQ : IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         req_pc      <= RESET_PC;
         outstanding <= 1'b0;
         discard     <= 1'b0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
         if (granted)
            req_pc <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch.
// Instance dut: RESET_PC=0 with a latency-programmable memory model.
// Instance dutb: RESET_PC=all-ones, grant tied high, one-cycle memory.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic        clk, reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;

   logic        b_req, b_rvalid, b_valid;
   logic [31:0] b_addr, b_rdata, b_instr, b_pc;

   int vectors = 0;
   int miscompares = 0;
   int cyc;

   // memory model knobs
   logic        gnt_en;
   int          lat;
   logic        inj_rv;
   logic        m_rv, m_pend;
   logic [31:0] m_rd, m_paddr;
   int          m_cnt;

   fetch_entry_t sb[$];
   fetch_entry_t e;
   logic [31:0]  addr_log[$];
   logic [31:0]  b_addr_log[$], b_pc_log[$], b_dat_log[$];

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   instr_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   instr_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFFF)) dutb (
      .clk(clk), .reset(reset),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(1'b1),
      .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
      .instr_valid(b_valid), .instr(b_instr), .instr_pc(b_pc),
      .instr_ready(1'b1)
   );

   assign imem_gnt    = gnt_en;
   assign imem_rvalid = m_rv | inj_rv;
   assign imem_rdata  = inj_rv ? 32'hBAD0_BAD0 : m_rd;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_rv <= 1'b0; m_pend <= 1'b0; m_cnt <= 0;
         m_rd <= '0;   m_paddr <= '0;
      end else begin
         m_rv <= 1'b0;
         if (m_pend) begin
            if (m_cnt <= 1) begin
               m_rv <= 1'b1; m_rd <= mem_data(m_paddr); m_pend <= 1'b0;
            end else m_cnt <= m_cnt - 1;
         end
         if (imem_req && imem_gnt) begin
            if (lat <= 1) begin
               m_rv <= 1'b1; m_rd <= mem_data(imem_addr);
            end else begin
               m_pend <= 1'b1; m_cnt <= lat - 1; m_paddr <= imem_addr;
            end
         end
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_rvalid <= 1'b0; b_rdata <= '0;
      end else begin
         b_rvalid <= b_req;
         b_rdata  <= mem_data(b_addr);
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Monitors: sample on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         if (imem_req && imem_gnt) addr_log.push_back(imem_addr);
         if (instr_valid && instr_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", instr_pc, instr);
            end else begin
               e = sb.pop_front();
               if (instr_pc !== e.pc || instr !== e.instr) begin
                  miscompares++;
                  $display("FAIL sb_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                           instr_pc, instr, e.pc, e.instr);
               end
            end
         end
         if (b_req) b_addr_log.push_back(b_addr);
         if (b_valid) begin
            b_pc_log.push_back(b_pc);
            b_dat_log.push_back(b_instr);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      fetch_entry_t x;
      x.pc = pc; x.instr = mem_data(pc);
      sb.push_back(x);
   endtask

   // Wait for the falling edge that follows rising edge k after release.
   task automatic at_neg(input int k);
      do @(negedge clk); while (cyc < k);
   endtask

   task automatic after_edge();
      @(posedge clk); #1;
   endtask

   task automatic restart(input logic rdy, input int l);
      after_edge();
      reset = 1'b0; redirect_valid = 1'b0; inj_rv = 1'b0;
      check("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      after_edge();
      addr_log.delete();
      gnt_en = 1'b1; lat = l; instr_ready = rdy;
      reset = 1'b1;
   endtask

   initial begin
      int first_v;
      int stuck;
      reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      instr_ready = 1'b1; gnt_en = 1'b1; lat = 1; inj_rv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",   32'(imem_req), 32'd0);
      check("rst_addr",  imem_addr, 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_pc",    instr_pc, 32'd0);
      check("b_rst_addr", b_addr, 32'hFFFF_FFFF);

      // 1: streaming, gnt tied high, one-cycle response
      for (int i = 0; i < 6; i++) expect_pc(32'(i));
      reset = 1'b1;
      first_v = 0;
      for (int k = 1; k <= 13; k++) begin
         at_neg(k);
         if (k == 1) begin
            check("first_req",  32'(imem_req), 32'd1);
            check("first_addr", imem_addr, 32'd0);
         end
         if (instr_valid && first_v == 0) first_v = k;
      end
      check("first_valid_cycle", 32'(first_v), 32'd3);
      check("stream_addr_count", 32'(addr_log.size() >= 6), 32'd1);
      for (int i = 0; i < 6; i++) check("stream_addr", addr_log[i], 32'(i));

      // 2: decode stalled, FIFO fills with PC 0,1 then fetch resumes at 2
      restart(1'b0, 1);
      at_neg(4);
      stuck = 0;
      for (int k = 5; k <= 10; k++) begin
         at_neg(k);
         if (imem_req) stuck++;
      end
      check("full_no_req", 32'(stuck), 32'd0);
      check("full_grants", 32'(addr_log.size()), 32'd2);
      check("full_valid",  32'(instr_valid), 32'd1);
      check("full_head_pc", instr_pc, 32'd0);
      for (int i = 0; i < 4; i++) expect_pc(32'(i));
      after_edge();
      instr_ready = 1'b1;
      at_neg(12);
      check("resume_req",  32'(imem_req), 32'd1);
      check("resume_addr", imem_addr, 32'd2);
      at_neg(16);

      // 3: redirect to 0x100 while waiting on PC 5
      restart(1'b1, 1);
      for (int i = 0; i < 5; i++) expect_pc(32'(i));
      expect_pc(32'h100); expect_pc(32'h101);
      at_neg(9);
      after_edge();
      lat = 3;
      at_neg(11);
      after_edge();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      after_edge();
      redirect_valid = 1'b0; lat = 1;
      at_neg(13);
      check("disc_req13", 32'(imem_req), 32'd0);
      at_neg(14);
      check("disc_req14", 32'(imem_req), 32'd0);
      at_neg(15);
      check("redir_req",   32'(imem_req), 32'd1);
      check("redir_addr",  imem_addr, 32'h100);
      check("redir_empty", 32'(instr_valid), 32'd0);
      at_neg(19);
      check("redir_log5", addr_log[5], 32'd5);
      check("redir_log6", addr_log[6], 32'h100);
      check("redir_log7", addr_log[7], 32'h101);

      // 4: redirect to 0x40 with rvalid and a pop in the same cycle
      restart(1'b0, 1);
      expect_pc(32'h0); expect_pc(32'h40); expect_pc(32'h41);
      at_neg(3);
      check("pre_valid", 32'(instr_valid), 32'd1);
      after_edge();
      redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
      at_neg(4);
      check("same_rvalid", 32'(imem_rvalid), 32'd1);
      after_edge();
      redirect_valid = 1'b0;
      at_neg(5);
      check("flush_empty", 32'(instr_valid), 32'd0);
      check("flush_req",   32'(imem_req), 32'd1);
      check("flush_addr",  imem_addr, 32'h40);
      at_neg(9);

      // 6: reset asserted in WAIT, then a stray rvalid before the new grant
      restart(1'b1, 3);
      at_neg(2);
      check("wait_req", 32'(imem_req), 32'd0);
      after_edge();
      reset = 1'b0;
      #1;
      check("mid_rst_req",   32'(imem_req), 32'd0);
      check("mid_rst_addr",  imem_addr, 32'd0);
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      check("mid_rst_instr", instr, 32'd0);
      check("mid_rst_pc",    instr_pc, 32'd0);
      after_edge();
      addr_log.delete();
      gnt_en = 1'b0; lat = 1; inj_rv = 1'b1; instr_ready = 1'b1;
      expect_pc(32'h0);
      reset = 1'b1;
      at_neg(1);
      check("rel_req",  32'(imem_req), 32'd1);
      check("rel_addr", imem_addr, 32'd0);
      after_edge();
      inj_rv = 1'b0; gnt_en = 1'b1;
      at_neg(2);
      check("stray_ignored2", 32'(instr_valid), 32'd0);
      at_neg(3);
      check("stray_ignored3", 32'(instr_valid), 32'd0);
      at_neg(4);
      check("rel_log0", addr_log[0], 32'd0);
      after_edge();
      check("sb_final", 32'(sb.size()), 32'd0);

      // 5: PC wrap on the all-ones reset instance (first run after reset)
      check("b_addr0", b_addr_log[0], 32'hFFFF_FFFF);
      check("b_addr1", b_addr_log[1], 32'h0000_0000);
      check("b_pc0",   b_pc_log[0],   32'hFFFF_FFFF);
      check("b_pc1",   b_pc_log[1],   32'h0000_0000);
      check("b_dat0",  b_dat_log[0],  32'hC0DE_FFFF);
      check("b_dat1",  b_dat_log[1],  32'hC0DE_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
